// File: rtl/flasher_pattern_monitor.sv
// rtl/flasher_pattern_monitor.sv - checks a 16-bit thermometer LED bar against the six-phase bounce pattern
module flasher_pattern_monitor #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [15:0]      led,
    output logic [4:0]       level,
    output logic [2:0]       phase,
    output logic             busy,
    output logic             dir_up,
    output logic             cycle_done,
    output logic             rewind,
    output logic [CNT_W-1:0] cycle_count,
    output logic             err,
    output logic [1:0]       err_code
);

    typedef enum logic {
        M_IDLE,
        M_RUN
    } mstate_t;

    localparam logic [1:0] E_NONE  = 2'd0;
    localparam logic [1:0] E_THERM = 2'd1;
    localparam logic [1:0] E_STEP  = 2'd2;
    localparam logic [1:0] E_OVER  = 2'd3;

    mstate_t          state_q, state_d;
    logic [2:0]       phase_q, phase_d;
    logic [4:0]       prev_q, prev_d;
    logic [4:0]       level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d;
    logic             done_q, done_d;
    logic             rewind_q, rewind_d;

    logic             legal;
    logic [4:0]       n;
    logic [4:0]       t;
    logic [1:0]       e;

    // Turning level of each phase; odd phases ramp down towards their target.
    function automatic logic [4:0] target(input logic [2:0] p);
        case (p)
            3'd0:    target = 5'd16;
            3'd1:    target = 5'd6;
            3'd2:    target = 5'd11;
            3'd3:    target = 5'd0;
            3'd4:    target = 5'd6;
            default: target = 5'd0;
        endcase
    endfunction

    // Thermometer decode: legal only when the bar is a contiguous run of ones from bit 0.
    always_comb begin
        legal = 1'b0;
        n     = 5'd0;
        for (int i = 0; i <= 16; i++) begin
            if (led == 16'((17'd1 << i) - 17'd1)) begin
                legal = 1'b1;
                n     = 5'(i);
            end
        end
    end

    // Pattern tracker: compares each enabled sample with the previous legal one.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        prev_d   = prev_q;
        level_d  = level_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        code_d   = code_q;
        done_d   = 1'b0;
        rewind_d = 1'b0;
        e        = E_NONE;
        t        = target(phase_q);
        if (en) begin
            if (!legal) begin
                e = E_THERM;
            end else begin
                level_d = n;
                prev_d  = n;
                if (state_q == M_IDLE) begin
                    if (n == 5'd0) begin
                        state_d = M_IDLE;
                    end else if (n == 5'd1 && prev_q == 5'd0) begin
                        state_d = M_RUN;
                        phase_d = 3'd0;
                    end else begin
                        e = E_STEP;
                    end
                end else if (!phase_q[0]) begin
                    if (n == prev_q + 5'd1 && n <= t) begin
                        phase_d = phase_q;
                    end else if (n > t) begin
                        e = E_OVER;
                    end else if (n == prev_q && n == t) begin
                        phase_d = phase_q + 3'd1;
                    end else begin
                        e = E_STEP;
                    end
                end else begin
                    if (n + 5'd1 == prev_q && n >= t) begin
                        phase_d = phase_q;
                    end else if (n < t) begin
                        e = E_OVER;
                    end else if (n == prev_q && n == t) begin
                        if (phase_q == 3'd5) begin
                            state_d = M_IDLE;
                            phase_d = 3'd0;
                            done_d  = 1'b1;
                            if (cnt_q != {CNT_W{1'b1}}) begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end else begin
                            phase_d = phase_q + 3'd1;
                        end
                    end else if (n == prev_q + 5'd1 && (prev_q == 5'd0 || prev_q == 5'd6)
                                 && (phase_q == 3'd1 || phase_q == 3'd3)) begin
                        // Flick: the flasher rewinds into the preceding up phase.
                        if (n > target(phase_q - 3'd1)) begin
                            e = E_OVER;
                        end else begin
                            phase_d  = phase_q - 3'd1;
                            rewind_d = 1'b1;
                        end
                    end else begin
                        e = E_STEP;
                    end
                end
            end
            // Any error drops back to idle and suppresses pulses; only the first code is kept.
            if (e != E_NONE) begin
                err_d    = 1'b1;
                state_d  = M_IDLE;
                phase_d  = 3'd0;
                done_d   = 1'b0;
                rewind_d = 1'b0;
                cnt_d    = cnt_q;
                if (code_q == E_NONE) begin
                    code_d = e;
                end
            end
        end
    end

    // State and status registers with synchronous reset taking priority over sampling.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= M_IDLE;
            phase_q  <= 3'd0;
            prev_q   <= 5'd0;
            level_q  <= 5'd0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            code_q   <= E_NONE;
            done_q   <= 1'b0;
            rewind_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            prev_q   <= prev_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            code_q   <= code_d;
            done_q   <= done_d;
            rewind_q <= rewind_d;
        end
    end

    assign level       = level_q;
    assign phase       = phase_q;
    assign busy        = (state_q == M_RUN);
    assign dir_up      = (state_q == M_RUN) && !phase_q[0];
    assign cycle_done  = done_q;
    assign rewind      = rewind_q;
    assign cycle_count = cnt_q;
    assign err         = err_q;
    assign err_code    = code_q;

endmodule
